// File: rtl/fsm_door_timed.sv
// Timed garage-door controller: Moore FSM with travel timeout,
// auto-close, direction-reversal dead time and a blinking fault state.
module fsm_door_timed #(
   parameter int unsigned TRAVEL_MAX = 20000000,
   parameter int unsigned OPEN_HOLD  = 10000000,
   parameter int unsigned DEAD_CYC   = 1000,
   parameter int unsigned CNT_W      = 25
) (
   input  logic clk2m,
   input  logic rst,
   input  logic key_up,
   input  logic key_down,
   input  logic sense_up,
   input  logic sense_down,
   input  logic obstacle,
   output logic ml,
   output logic mr,
   output logic light_red,
   output logic light_green,
   output logic fault
);

   localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;
   localparam int unsigned BW = CNT_W - 4;

   if (64'(TRAVEL_MAX) > CMAX || 64'(OPEN_HOLD) > CMAX ||
       64'(DEAD_CYC) > CMAX || CNT_W < 5 || CNT_W > 32 ||
       TRAVEL_MAX == 0 || DEAD_CYC == 0) begin : g_param_err
      $error("fsm_door_timed: timing parameter out of range");
   end

   localparam logic [CNT_W-1:0] TRAVEL_END = CNT_W'(TRAVEL_MAX - 1);
   localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(OPEN_HOLD - 1);
   localparam logic [CNT_W-1:0] DEAD_END   = CNT_W'(DEAD_CYC - 1);
   localparam bit               HOLD_ON    = (OPEN_HOLD != 0);

   typedef enum logic [2:0] {
      START_UP,
      IS_OPEN,
      IS_CLOSED,
      DRV_OPEN,
      DRV_CLOSED,
      DEAD_OPEN,
      DEAD_CLOSE,
      FAULT
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [BW-1:0]    blink;
   logic             hold_clr;
   logic             up_only;
   logic             dn_only;

   // Simultaneous keys cancel each other outside FAULT.
   assign up_only = key_up && !key_down;
   assign dn_only = key_down && !key_up;

   always_comb begin
      nxt      = state;
      hold_clr = 1'b0;
      if (sense_up && sense_down) begin
         nxt = FAULT;
      end else begin
         case (state)
            START_UP: begin
               if (sense_down)   nxt = IS_CLOSED;
               else if (sense_up) nxt = IS_OPEN;
               else if (up_only)  nxt = DRV_OPEN;
               else if (dn_only)  nxt = DRV_CLOSED;
            end
            IS_CLOSED: begin
               if (up_only) nxt = DRV_OPEN;
            end
            IS_OPEN: begin
               if (obstacle)     hold_clr = 1'b1;
               else if (dn_only) nxt = DRV_CLOSED;
               else if (HOLD_ON && cnt == HOLD_END) nxt = DRV_CLOSED;
            end
            DRV_OPEN: begin
               if (sense_up)               nxt = IS_OPEN;
               else if (dn_only)           nxt = DEAD_CLOSE;
               else if (cnt == TRAVEL_END) nxt = FAULT;
            end
            DRV_CLOSED: begin
               if (sense_down)               nxt = IS_CLOSED;
               else if (obstacle || up_only) nxt = DEAD_OPEN;
               else if (cnt == TRAVEL_END)   nxt = FAULT;
            end
            DEAD_OPEN: begin
               if (cnt == DEAD_END) nxt = DRV_OPEN;
            end
            DEAD_CLOSE: begin
               if (obstacle)             nxt = DEAD_OPEN;
               else if (cnt == DEAD_END) nxt = DRV_CLOSED;
            end
            FAULT: begin
               if (key_up && key_down) nxt = START_UP;
            end
            default: nxt = START_UP;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state.
   always_ff @(posedge clk2m) begin
      if (rst) begin
         state       <= START_UP;
         cnt         <= '0;
         blink       <= '0;
         ml          <= 1'b0;
         mr          <= 1'b0;
         light_red   <= 1'b0;
         light_green <= 1'b0;
         fault       <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt != state || hold_clr) cnt <= '0;
         else if (cnt != '1)           cnt <= cnt + CNT_W'(1);

         mr          <= (nxt == DRV_OPEN);
         ml          <= (nxt == DRV_CLOSED);
         light_green <= (nxt == IS_OPEN);
         fault       <= (nxt == FAULT);

         if (nxt == FAULT) begin
            if (state != FAULT) begin
               blink     <= '0;
               light_red <= 1'b1;
            end else begin
               blink <= blink + BW'(1);
               if (&blink) light_red <= ~light_red;
            end
         end else begin
            blink     <= '0;
            light_red <= (nxt != START_UP) && (nxt != IS_OPEN);
         end
      end
   end

endmodule

// File: tb/tb_fsm_door_timed.sv
// Scoreboard bench for fsm_door_timed with short timing parameters.
// Output vector order: {ml, mr, light_red, light_green, fault}.
module tb_fsm_door_timed;

   logic clk2m = 1'b0;
   logic rst;
   logic key_up, key_down, sense_up, sense_down, obstacle;
   logic ml, mr, light_red, light_green, fault;

   int checks = 0;
   int errors = 0;
   int overlap = 0;

   typedef struct {
      string      tag;
      logic [4:0] exp;
   } sb_t;

   sb_t sbq[$];

   localparam logic [4:0] O_START  = 5'b00000;
   localparam logic [4:0] O_CLOSED = 5'b00100;
   localparam logic [4:0] O_DEAD   = 5'b00100;
   localparam logic [4:0] O_OPEN   = 5'b00010;
   localparam logic [4:0] O_DOPEN  = 5'b01100;
   localparam logic [4:0] O_DCLOSE = 5'b10100;
   localparam logic [4:0] O_FAULT  = 5'b00101;
   localparam logic [4:0] O_FBLINK = 5'b00001;

   // Inputs: {rst, key_up, key_down, sense_up, sense_down, obstacle}
   localparam logic [5:0] I_RST  = 6'b100000;
   localparam logic [5:0] I_IDLE = 6'b000000;
   localparam logic [5:0] I_KU   = 6'b010000;
   localparam logic [5:0] I_KD   = 6'b001000;
   localparam logic [5:0] I_KB   = 6'b011000;
   localparam logic [5:0] I_SU   = 6'b000100;
   localparam logic [5:0] I_SD   = 6'b000010;
   localparam logic [5:0] I_SB   = 6'b000110;
   localparam logic [5:0] I_OB   = 6'b000001;

   fsm_door_timed #(
      .TRAVEL_MAX(16),
      .OPEN_HOLD (8),
      .DEAD_CYC  (4),
      .CNT_W     (8)
   ) dut (
      .clk2m      (clk2m),
      .rst        (rst),
      .key_up     (key_up),
      .key_down   (key_down),
      .sense_up   (sense_up),
      .sense_down (sense_down),
      .obstacle   (obstacle),
      .ml         (ml),
      .mr         (mr),
      .light_red  (light_red),
      .light_green(light_green),
      .fault      (fault)
   );

   always #5 clk2m = ~clk2m;

   always @(negedge clk2m) begin
      if (ml && mr) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [5:0] in, input logic [4:0] exp,
                      input string tag);
      sb_t e;
      {rst, key_up, key_down, sense_up, sense_down, obstacle} = in;
      e.tag = tag;
      e.exp = exp;
      sbq.push_back(e);
      @(posedge clk2m);
      #1;
      if (sbq.size() == 0) begin
         chk({tag, "_empty"}, 1, 0);
      end else begin
         e = sbq.pop_front();
         chk(e.tag, {27'd0, ml, mr, light_red, light_green, fault},
             {27'd0, e.exp});
      end
   endtask

   initial begin
      {rst, key_up, key_down, sense_up, sense_down, obstacle} = I_RST;
      @(posedge clk2m);
      #1;
      cyc(I_RST, O_START, "reset");
      cyc(I_IDLE, O_START, "start_hold");

      cyc(I_SD, O_CLOSED, "to_closed");
      cyc(I_KU | I_SD, O_DOPEN, "key_up_open");
      for (int i = 1; i <= 4; i++) cyc(I_IDLE, O_DOPEN, "drv_open");
      cyc(I_SU, O_OPEN, "sense_up_open");

      for (int i = 1; i <= 8; i++)
         cyc(I_SU, (i == 8) ? O_DCLOSE : O_OPEN, "auto_close");

      cyc(I_OB, O_DEAD, "obst_rev");
      for (int i = 1; i <= 4; i++)
         cyc(I_IDLE, (i == 4) ? O_DOPEN : O_DEAD, "dead_open");
      cyc(I_SU, O_OPEN, "reopen");

      for (int i = 1; i <= 5; i++) cyc(I_SU, O_OPEN, "open_pre_obst");
      cyc(I_SU | I_OB, O_OPEN, "open_obst");
      for (int i = 1; i <= 8; i++)
         cyc(I_SU, (i == 8) ? O_DCLOSE : O_OPEN, "obst_restart");

      cyc(I_SD, O_CLOSED, "closed_again");
      cyc(I_KB | I_SD, O_CLOSED, "both_keys_ign");
      cyc(I_KB | I_SD, O_CLOSED, "both_keys_ign2");

      cyc(I_KU, O_DOPEN, "timeout_start");
      for (int i = 1; i <= 16; i++)
         cyc(I_IDLE, (i == 16) ? O_FAULT : O_DOPEN, "travel_timeout");
      for (int i = 1; i <= 16; i++)
         cyc(I_KU, (i == 16) ? O_FBLINK : O_FAULT, "fault_blink");
      cyc(I_KB, O_START, "fault_clear");

      cyc(I_SU, O_OPEN, "start_sense_up");
      cyc(I_SB, O_FAULT, "sense_both_open");
      cyc(I_KB, O_START, "fault_clear2");
      cyc(I_KD, O_DCLOSE, "start_key_down");
      cyc(I_SB, O_FAULT, "sense_both_drv");
      cyc(I_KB, O_START, "fault_clear3");

      cyc(I_KU, O_DOPEN, "open_for_rev");
      cyc(I_KD, O_DEAD, "rev_close");
      for (int i = 1; i <= 4; i++)
         cyc(I_IDLE, (i == 4) ? O_DCLOSE : O_DEAD, "dead_close");
      cyc(I_KU, O_DEAD, "key_rev");
      for (int i = 1; i <= 4; i++)
         cyc(I_IDLE, (i == 4) ? O_DOPEN : O_DEAD, "dead_open2");
      cyc(I_KD, O_DEAD, "rev_close2");
      cyc(I_IDLE, O_DEAD, "dead_close_c1");
      cyc(I_OB, O_DEAD, "dead_close_obst");
      for (int i = 1; i <= 4; i++)
         cyc(I_IDLE, (i == 4) ? O_DOPEN : O_DEAD, "dead_obst_open");

      cyc(I_IDLE, O_DOPEN, "pre_rst");
      cyc(I_RST, O_START, "rst_mid_travel");
      cyc(I_IDLE, O_START, "post_rst_hold");

      chk("no_ml_mr_overlap", overlap, 0);
      chk("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
